// File: rtl/gmii_tx_arb.sv
// -----------------------------------------------------------------------------
// gmii_tx_arb
//
// Two-requester GMII transmit arbiter. Grants the transmitter round-robin,
// frames each payload with a 7x 0x55 + 0xD5 preamble, aborts oversize frames
// or frames cut short by loss of link, and enforces an inter-packet gap.
//
// Parameters
//   IPG      idle octets on the bus between frames
//   MAX_LEN  payload octets after which an unterminated frame is aborted
//
// Ports
//   clk              125 MHz GMII transmit clock
//   rst              asynchronous active-high reset
//   operate          link ready; low aborts a frame in progress
//   req0/req1        requester has a frame pending
//   data0/data1      requester payload octet, consumed while strobeN is high
//   last0/last1      current octet is the final octet of the frame
//   grant0/grant1    requester owns the transmitter (PRE and DATA states)
//   strobe0/strobe1  requester octet consumed this cycle
//   TXD/TX_EN/TX_ER  registered GMII transmit bus
//
// Bus timing: the octet presented in a DATA cycle appears on TXD one clock
// later, so the final payload octet (or the error octet of an abort) is on the
// bus during the first GAP cycle. The GAP state therefore lasts IPG cycles and,
// together with the single IDLE decision cycle, gives exactly IPG TX_EN-low
// octets between back-to-back frames.
// -----------------------------------------------------------------------------
module gmii_tx_arb #(
    parameter int IPG     = 12,
    parameter int MAX_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       operate,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       grant0,
    output logic       grant1,
    output logic       strobe0,
    output logic       strobe1,
    output logic [7:0] TXD,
    output logic       TX_EN,
    output logic       TX_ER
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int         GAP_W    = (IPG > 15) ? $clog2(IPG + 1) : 4;
    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] SFD      = 8'hD5;

    logic [1:0]       r_state;
    logic             r_owner;       // requester holding the current grant
    logic             r_last_owner;  // requester granted most recently
    logic [2:0]       r_pre_cnt;
    logic [10:0]      r_len;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [7:0]       r_txd;
    logic             r_tx_en;
    logic             r_tx_er;

    logic       w_busy;
    logic       w_start;
    logic       w_pick;
    logic       w_abort;
    logic       w_strobe;
    logic [7:0] w_data;
    logic       w_last;

    assign w_busy  = (r_state == S_PRE) || (r_state == S_DATA);
    assign w_start = (r_state == S_IDLE) && operate && (req0 || req1);

    // On contention the requester that did not win last time goes next.
    assign w_pick = (req0 && req1) ? ~r_last_owner : req1;

    // Loss of link during the frame, or a payload that has reached MAX_LEN
    // octets without a last marker, kills the frame in this cycle.
    assign w_abort = w_busy &&
                     (!operate || ((r_state == S_DATA) && (r_len == 11'(MAX_LEN))));

    assign w_strobe = (r_state == S_DATA) && !w_abort;
    assign w_data   = r_owner ? data1 : data0;
    assign w_last   = r_owner ? last1 : last0;

    // Grants and strobes decode straight from state so that an asynchronous
    // reset removes them in the same cycle.
    assign grant0  = w_busy && !r_owner;
    assign grant1  = w_busy &&  r_owner;
    assign strobe0 = w_strobe && !r_owner;
    assign strobe1 = w_strobe &&  r_owner;

    assign TXD   = r_txd;
    assign TX_EN = r_tx_en;
    assign TX_ER = r_tx_er;

    // NOTE: every state register uses non-blocking assignment so all of them
    // update from the same pre-edge values, and the reset branch is part of
    // the sensitivity list so it acts without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;  // requester 0 wins the first contention
            r_pre_cnt    <= '0;
            r_len        <= '0;
            r_gap_cnt    <= '0;
            r_txd        <= 8'h00;
            r_tx_en      <= 1'b0;
            r_tx_er      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd   <= 8'h00;
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                    if (w_start) begin
                        r_state      <= S_PRE;
                        r_owner      <= w_pick;
                        r_last_owner <= w_pick;
                        r_pre_cnt    <= '0;
                        r_len        <= '0;
                        r_txd        <= PREAMBLE;
                        r_tx_en      <= 1'b1;
                    end
                end

                S_PRE: begin
                    if (w_abort) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                        r_txd     <= 8'h00;
                        r_tx_en   <= 1'b1;
                        r_tx_er   <= 1'b1;
                    end else if (r_pre_cnt == 3'd6) begin
                        // Seventh 0x55 is on the bus; SFD goes out while the
                        // first payload octet is being strobed.
                        r_state <= S_DATA;
                        r_txd   <= SFD;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 3'd1;
                        r_txd     <= PREAMBLE;
                    end
                end

                S_DATA: begin
                    if (w_abort) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                        r_txd     <= 8'h00;
                        r_tx_en   <= 1'b1;
                        r_tx_er   <= 1'b1;
                    end else begin
                        r_txd   <= w_data;
                        r_tx_en <= 1'b1;
                        r_tx_er <= 1'b0;
                        r_len   <= r_len + 11'd1;
                        if (w_last) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= '0;
                        end
                    end
                end

                S_GAP: begin
                    r_txd   <= 8'h00;
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                    if (r_gap_cnt == GAP_W'(IPG - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_gmii_tx_arb
//
// Self-checking bench for gmii_tx_arb. The bench plays both requesters from
// per-requester octet queues, checks an arbitration table, hand-written
// sequences for the multi-cycle corner cases (basic frame, oversize abort,
// link loss, reset during preamble), and a randomized run compared cycle by
// cycle with a frame-level timing model.
// -----------------------------------------------------------------------------
module tb_gmii_tx_arb;

    localparam int IPG     = 12;
    localparam int MAX_LEN = 1518;
    localparam int TR_LEN  = 4096;

    logic       clk;
    logic       rst;
    logic       operate;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       last0, last1;
    logic       grant0, grant1;
    logic       strobe0, strobe1;
    logic [7:0] TXD;
    logic       TX_EN;
    logic       TX_ER;

    gmii_tx_arb #(.IPG(IPG), .MAX_LEN(MAX_LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .operate (operate),
        .req0    (req0),
        .req1    (req1),
        .data0   (data0),
        .data1   (data1),
        .last0   (last0),
        .last1   (last1),
        .grant0  (grant0),
        .grant1  (grant1),
        .strobe0 (strobe0),
        .strobe1 (strobe1),
        .TXD     (TXD),
        .TX_EN   (TX_EN),
        .TX_ER   (TX_ER)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // One cycle of observable outputs.
    typedef struct packed {
        logic [7:0] txd;
        logic       en;
        logic       er;
        logic       g0;
        logic       g1;
        logic       s0;
        logic       s1;
    } obs_t;

    // Arbitration table row: stimulus and hand-derived expectations.
    typedef struct {
        bit       r0;
        bit       r1;
        int       len;
        bit [1:0] exp_g;   // {grant1, grant0} in the first granted cycle
        int       exp_en;  // TX_EN-high cycles of the frame
        int       exp_st;  // strobes issued for the frame
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] pay0[$], pay1[$];
    bit         lst0[$], lst1[$];

    obs_t smp;
    int   en_cnt, st_cnt, g_cnt, pre_cnt55;
    int   cyc;
    bit   rand_req;

    // Frame-level reference model state.
    bit   model_on;
    int   model_free;
    bit   model_last;
    obs_t exp_tr[TR_LEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_data();
        data0 = (pay0.size() > 0) ? pay0[0] : 8'h00;
        last0 = (lst0.size() > 0) ? lst0[0] : 1'b0;
        data1 = (pay1.size() > 0) ? pay1[0] : 8'h00;
        last1 = (lst1.size() > 0) ? lst1[0] : 1'b0;
    endtask

    task automatic push_frame(input bit n, input int len, input bit incr, input bit no_last);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = incr ? 8'(i + 1) : 8'($urandom);
            if (!n) begin
                pay0.push_back(b);
                lst0.push_back(!no_last && (i == len - 1));
            end else begin
                pay1.push_back(b);
                lst1.push_back(!no_last && (i == len - 1));
            end
        end
        drive_data();
    endtask

    task automatic clear_q();
        pay0.delete(); lst0.delete();
        pay1.delete(); lst1.delete();
        drive_data();
    endtask

    // When the transmitter is free and someone requests, predict the whole
    // frame on the bus: 7 preamble octets, SFD, payload, then IPG idle octets
    // before the next arbitration decision.
    task automatic model_decide();
        bit   w;
        int   len;
        obs_t e;
        if (cyc >= model_free && operate && (req0 || req1)) begin
            w = (req0 && req1) ? !model_last : req1;
            model_last = w;
            len = 0;
            if (!w) begin
                while (len < lst0.size() - 1 && !lst0[len]) len++;
            end else begin
                while (len < lst1.size() - 1 && !lst1[len]) len++;
            end
            len++;
            for (int k = 1; k <= 8 + len; k++) begin
                e     = '0;
                e.en  = 1'b1;
                e.txd = (k <= 7) ? 8'h55 : (k == 8) ? 8'hD5 : (w ? pay1[k-9] : pay0[k-9]);
                e.g0  = !w && (k <= 7 + len);
                e.g1  =  w && (k <= 7 + len);
                e.s0  = !w && (k >= 8) && (k <= 7 + len);
                e.s1  =  w && (k >= 8) && (k <= 7 + len);
                if (cyc + k < TR_LEN) exp_tr[cyc + k] = e;
            end
            model_free = cyc + 8 + len + IPG;
        end
    endtask

    // NOTE: outputs are sampled on the falling edge and inputs are changed
    // 1 time unit after the rising edge, so neither races the DUT's flops.
    task automatic step();
        @(negedge clk);
        smp = {TXD, TX_EN, TX_ER, grant0, grant1, strobe0, strobe1};
        if (smp.en) en_cnt++;
        if (smp.s0 || smp.s1) st_cnt++;
        if (smp.g0 || smp.g1) g_cnt++;
        if (smp.en && smp.txd == 8'h55) pre_cnt55++;
        if (model_on && cyc < TR_LEN) begin
            model_decide();
            check($sformatf("model_cycle%0d", cyc), 32'(smp), 32'(exp_tr[cyc]));
        end
        @(posedge clk);
        #1;
        if (smp.s0 && pay0.size() > 0) begin
            void'(pay0.pop_front());
            void'(lst0.pop_front());
        end
        if (smp.s1 && pay1.size() > 0) begin
            void'(pay1.pop_front());
            void'(lst1.pop_front());
        end
        if (rand_req) begin
            req0 = (pay0.size() > 0) && (cyc < 400 || $urandom_range(3) != 0);
            req1 = (pay1.size() > 0) && (cyc < 400 || $urandom_range(3) != 0);
        end
        drive_data();
        cyc++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        operate  = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        rand_req = 1'b0;
        model_on = 1'b0;
        clear_q();
        step();
        step();
        rst = 1'b0;
    endtask

    // Returns the number of cycles until a grant is seen, or -1 on timeout.
    task automatic wait_grant(input string name, output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (smp.g0 || smp.g1) begin
                n = i;
                break;
            end
        end
        check({name, "_grant_seen"}, (n > 0), 1);
    endtask

    task automatic wait_en_low(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (!smp.en) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_en_drop"}, ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[8];
        int         n;
        logic [8:0] tr[24];
        logic [8:0] exp9;
        logic [7:0] b5;
        bit         ok;

        tbl[0] = '{1, 1, 4, 2'b01, 12, 4};
        tbl[1] = '{1, 1, 1, 2'b10,  9, 1};
        tbl[2] = '{0, 1, 1, 2'b10,  9, 1};
        tbl[3] = '{1, 1, 2, 2'b01, 10, 2};
        tbl[4] = '{1, 0, 3, 2'b01, 11, 3};
        tbl[5] = '{1, 1, 5, 2'b10, 13, 5};
        tbl[6] = '{1, 1, 2, 2'b01, 10, 2};
        tbl[7] = '{0, 1, 6, 2'b10, 14, 6};

        cyc        = 0;
        model_free = 0;
        model_last = 1'b1;
        en_cnt = 0; st_cnt = 0; g_cnt = 0; pre_cnt55 = 0;

        // ---- reset state ----------------------------------------------------
        do_reset();
        rst = 1'b1;
        req0 = 1'b1;
        operate = 1'b1;
        push_frame(0, 2, 1, 0);
        step();
        check("reset_outputs", 32'(smp), 0);
        do_reset();

        // ---- arbitration table ----------------------------------------------
        operate = 1'b1;
        foreach (tbl[r]) begin
            clear_q();
            if (tbl[r].r0) push_frame(0, tbl[r].len, 0, 0);
            if (tbl[r].r1) push_frame(1, tbl[r].len, 0, 0);
            req0 = tbl[r].r0;
            req1 = tbl[r].r1;
            en_cnt = 0; st_cnt = 0;
            wait_grant($sformatf("row%0d", r), n);
            req0 = 1'b0;
            req1 = 1'b0;
            check($sformatf("row%0d_winner", r), {smp.g1, smp.g0}, tbl[r].exp_g);
            wait_en_low($sformatf("row%0d", r), 100);
            check($sformatf("row%0d_en_cycles", r), en_cnt, tbl[r].exp_en);
            check($sformatf("row%0d_strobes", r), st_cnt, tbl[r].exp_st);
        end

        // ---- 4-octet frame 01..04, then the idle gap ------------------------
        do_reset();
        operate = 1'b1;
        push_frame(0, 4, 1, 0);
        req0 = 1'b1;
        wait_grant("basic", n);
        req0 = 1'b0;
        tr[0] = {smp.en, smp.txd};
        for (int i = 1; i < 24; i++) begin
            step();
            tr[i] = {smp.en, smp.txd};
        end
        for (int i = 0; i < 24; i++) begin
            if (i < 7)       exp9 = {1'b1, 8'h55};
            else if (i == 7) exp9 = {1'b1, 8'hD5};
            else if (i < 12) exp9 = {1'b1, 8'(i - 7)};
            else             exp9 = 9'h000;
            check($sformatf("basic_octet%0d", i), tr[i], exp9);
        end

        // ---- no last: abort after MAX_LEN payload octets ---------------------
        do_reset();
        operate = 1'b1;
        push_frame(0, MAX_LEN + 80, 0, 1);
        req0 = 1'b1;
        st_cnt = 0;
        wait_grant("maxlen", n);
        req0 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < MAX_LEN + 40; i++) begin
            step();
            if (!smp.g0) begin
                ok = 1'b1;
                break;
            end
        end
        check("maxlen_grant_drop", ok, 1);
        check("maxlen_strobes", st_cnt, MAX_LEN);
        check("maxlen_error_octet", {smp.en, smp.er, smp.txd}, {1'b1, 1'b1, 8'h00});
        en_cnt = 0;
        for (int i = 0; i < IPG; i++) step();
        check("maxlen_idle_after", en_cnt, 0);

        // ---- link loss during payload octet 5 --------------------------------
        do_reset();
        operate = 1'b1;
        push_frame(1, 20, 0, 0);
        b5 = pay1[4];
        req1 = 1'b1;
        st_cnt = 0;
        wait_grant("oplow", n);
        req1 = 1'b0;
        for (int i = 0; i < 30 && st_cnt < 5; i++) step();
        check("oplow_strobes_before", st_cnt, 5);
        operate = 1'b0;
        step();
        check("oplow_abort_cycle", {smp.s1, smp.g1, smp.en, smp.er, smp.txd},
              {1'b0, 1'b1, 1'b1, 1'b0, b5});
        step();
        check("oplow_error_octet", {smp.g1, smp.en, smp.er, smp.txd},
              {1'b0, 1'b1, 1'b1, 8'h00});
        pay1.delete(); lst1.delete();
        push_frame(0, 3, 0, 0);
        req0 = 1'b1;
        g_cnt = 0;
        for (int i = 0; i < 3; i++) step();
        check("oplow_no_grant", g_cnt, 0);
        operate = 1'b1;
        // 8 remaining gap cycles, 1 idle decision cycle, then the grant.
        wait_grant("oplow_regrant", n);
        req0 = 1'b0;
        check("oplow_regrant_delay", n, 10);
        check("oplow_regrant_who", {smp.g1, smp.g0}, 2'b01);
        wait_en_low("oplow_regrant", 100);

        // ---- reset during preamble -------------------------------------------
        do_reset();
        operate = 1'b1;
        push_frame(0, 4, 0, 0);
        req0 = 1'b1;
        wait_grant("rstpre", n);
        req0 = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("rstpre_immediate", {TX_EN, TX_ER, TXD, grant0, grant1, strobe0, strobe1}, 0);
        step();
        check("rstpre_held", 32'(smp), 0);
        rst = 1'b0;
        clear_q();
        push_frame(1, 2, 0, 0);
        req1 = 1'b1;
        en_cnt = 0; pre_cnt55 = 0;
        wait_grant("rstpre_next", n);
        req1 = 1'b0;
        check("rstpre_next_who", {smp.g1, smp.g0}, 2'b10);
        wait_en_low("rstpre_next", 100);
        check("rstpre_next_en_cycles", en_cnt, 10);
        check("rstpre_next_preamble", pre_cnt55 >= 7, 1);

        // ---- randomized traffic against the frame model ----------------------
        do_reset();
        foreach (exp_tr[i]) exp_tr[i] = '0;
        cyc        = 0;
        model_free = 0;
        model_last = 1'b1;
        model_on   = 1'b1;
        rand_req   = 1'b1;
        operate    = 1'b1;
        while (cyc < 1500) begin
            if (pay0.size() < 40 && $urandom_range(7) == 0)
                push_frame(0, $urandom_range(1, 16), 0, 0);
            if (pay1.size() < 40 && $urandom_range(7) == 0)
                push_frame(1, $urandom_range(1, 16), 0, 0);
            step();
        end
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (pay0.size() == 0 && pay1.size() == 0 && cyc > model_free + 2) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("random_drain", ok, 1);
        model_on = 1'b0;
        rand_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
